// File: rtl/multicycle_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_sequencer
// Description : Multi-cycle FETCH/DECODE/EXEC/MEM/WB controller for the 8-bit
//               ExceptioNull core. Owns the PC, latches the instruction word,
//               drives ALU / register-file / data-memory control and resolves
//               jumps and branches.
//               Optional feature macro: SINGLE_STEP_EN (adds the step port;
//               each step pulse retires exactly one instruction).
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_sequencer #(
    parameter int PC_W     = 8,
    parameter int RESET_PC = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [7:0]      imem_rdata,
    output logic            dmem_req,
    output logic            dmem_we,
    input  logic            dmem_ack,
    input  logic            alu_zero,
    output logic [2:0]      alu_control,
    output logic            alu_src,
    output logic            alu_cmp,
    output logic            wren_reg,
    output logic            datamem_toreg,
    output logic            link_sel,
    output logic [PC_W-1:0] pc,
    output logic [7:0]      ir,
    output logic [2:0]      state
`ifdef SINGLE_STEP_EN
    ,
    input  logic            step
`endif
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_t;

    localparam logic [3:0] c_OP_J    = 4'h8;
    localparam logic [3:0] c_OP_JAL  = 4'h9;
    localparam logic [3:0] c_OP_LW   = 4'hA;
    localparam logic [3:0] c_OP_SW   = 4'hB;
    localparam logic [3:0] c_OP_BEQ  = 4'hC;
    localparam logic [3:0] c_OP_BNE  = 4'hD;
    localparam logic [3:0] c_OP_ADDI = 4'hE;
    localparam logic [3:0] c_OP_LI   = 4'hF;

    localparam logic [2:0] c_ALU_MOV = 3'b000;
    localparam logic [2:0] c_ALU_ADD = 3'b001;

    // In single-step mode a fresh FETCH waits for a step pulse instead of
    // requesting immediately.
`ifdef SINGLE_STEP_EN
    localparam logic c_AUTO_REQ = 1'b0;
`else
    localparam logic c_AUTO_REQ = 1'b1;
`endif

    state_t          r_state;
    logic [PC_W-1:0] r_pc;
    logic [7:0]      r_ir;
`ifdef SINGLE_STEP_EN
    logic            r_step_pending;
`endif

    logic [3:0]      w_op;
    logic [PC_W-1:0] w_branch_target;
    logic            w_taken;
    logic            w_is_mem;

    // Opcode decode and branch resolution from the latched instruction.
    // The target uses the already-incremented pc, so offsets are relative to
    // the instruction after the branch.
    assign w_op            = r_ir[7:4];
    assign w_branch_target = r_pc + {{(PC_W-4){r_ir[3]}}, r_ir[3:0]};
    assign w_taken         = (alu_zero == (w_op == c_OP_BEQ));
    assign w_is_mem        = (w_op == c_OP_LW) || (w_op == c_OP_SW);

    assign imem_addr = r_pc;
    assign pc        = r_pc;
    assign ir        = r_ir;
    assign state     = r_state;

    // Sequencer: state, PC, IR and every control output are registered here
    // so each output is glitch-free and changes only on state transitions.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= S_FETCH;
            r_pc           <= PC_W'(RESET_PC);
            r_ir           <= 8'h00;
            imem_req       <= 1'b0;
            dmem_req       <= 1'b0;
            dmem_we        <= 1'b0;
            alu_control    <= 3'b000;
            alu_src        <= 1'b0;
            alu_cmp        <= 1'b0;
            wren_reg       <= 1'b0;
            datamem_toreg  <= 1'b0;
            link_sel       <= 1'b0;
`ifdef SINGLE_STEP_EN
            r_step_pending <= 1'b0;
`endif
        end else begin
            unique case (r_state)
                S_FETCH: begin
                    if (imem_req && imem_ack) begin
                        r_ir     <= imem_rdata;
                        r_pc     <= r_pc + PC_W'(1);
                        imem_req <= 1'b0;
                        r_state  <= S_DECODE;
                    end else if (!imem_req) begin
`ifdef SINGLE_STEP_EN
                        // A pulse is remembered for one cycle and then turned
                        // into a fetch; pulses outside idle FETCH are dropped.
                        if (r_step_pending) begin
                            imem_req       <= 1'b1;
                            r_step_pending <= 1'b0;
                        end else if (step) begin
                            r_step_pending <= 1'b1;
                        end
`else
                        imem_req <= 1'b1;
`endif
                    end
                end

                S_DECODE: begin
                    // Set up the ALU so its controls are valid for all of EXEC.
                    unique case (w_op)
                        c_OP_ADDI, c_OP_LW, c_OP_SW: begin
                            alu_control <= c_ALU_ADD;
                            alu_src     <= 1'b1;
                            alu_cmp     <= 1'b0;
                        end
                        c_OP_LI: begin
                            alu_control <= c_ALU_MOV;
                            alu_src     <= 1'b1;
                            alu_cmp     <= 1'b0;
                        end
                        c_OP_BEQ, c_OP_BNE: begin
                            alu_control <= c_ALU_MOV;
                            alu_src     <= 1'b0;
                            alu_cmp     <= 1'b1;
                        end
                        c_OP_J, c_OP_JAL: begin
                            alu_control <= c_ALU_MOV;
                            alu_src     <= 1'b0;
                            alu_cmp     <= 1'b0;
                        end
                        default: begin
                            alu_control <= w_op[2:0];
                            alu_src     <= 1'b0;
                            alu_cmp     <= 1'b0;
                        end
                    endcase
                    r_state <= S_EXEC;
                end

                S_EXEC: begin
                    // Loads/stores keep the address calculation alive in MEM.
                    if (!w_is_mem) begin
                        alu_control <= 3'b000;
                        alu_src     <= 1'b0;
                        alu_cmp     <= 1'b0;
                    end
                    unique case (w_op)
                        c_OP_LW, c_OP_SW: begin
                            dmem_req <= 1'b1;
                            dmem_we  <= (w_op == c_OP_SW);
                            r_state  <= S_MEM;
                        end
                        c_OP_J: begin
                            r_pc     <= w_branch_target;
                            imem_req <= c_AUTO_REQ;
                            r_state  <= S_FETCH;
                        end
                        c_OP_JAL: begin
                            r_pc     <= w_branch_target;
                            wren_reg <= 1'b1;
                            link_sel <= 1'b1;
                            r_state  <= S_WB;
                        end
                        c_OP_BEQ, c_OP_BNE: begin
                            if (w_taken) begin
                                r_pc <= w_branch_target;
                            end
                            imem_req <= c_AUTO_REQ;
                            r_state  <= S_FETCH;
                        end
                        default: begin
                            wren_reg <= 1'b1;
                            r_state  <= S_WB;
                        end
                    endcase
                end

                S_MEM: begin
                    if (dmem_ack) begin
                        dmem_req    <= 1'b0;
                        dmem_we     <= 1'b0;
                        alu_control <= 3'b000;
                        alu_src     <= 1'b0;
                        alu_cmp     <= 1'b0;
                        if (w_op == c_OP_LW) begin
                            wren_reg      <= 1'b1;
                            datamem_toreg <= 1'b1;
                            r_state       <= S_WB;
                        end else begin
                            imem_req <= c_AUTO_REQ;
                            r_state  <= S_FETCH;
                        end
                    end
                end

                S_WB: begin
                    // Register write lasts exactly this one cycle.
                    wren_reg      <= 1'b0;
                    datamem_toreg <= 1'b0;
                    link_sel      <= 1'b0;
                    imem_req      <= c_AUTO_REQ;
                    r_state       <= S_FETCH;
                end

                default: begin
                    r_state <= S_FETCH;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_multicycle_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_multicycle_sequencer
// Description : Scoreboard bench for multicycle_sequencer. Memory responders
//               with random wait states issue instructions; a reference model
//               predicts each instruction's effect and a monitor compares it
//               when the next fetch request appears.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_sequencer;

    localparam int PC_W   = 8;
    localparam int N_RAND = 500;

`ifdef SINGLE_STEP_EN
    localparam int   c_STEP_EXTRA    = 2;
    localparam logic c_REQ_AFTER_RST = 1'b0;
`else
    localparam int   c_STEP_EXTRA    = 0;
    localparam logic c_REQ_AFTER_RST = 1'b1;
`endif

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            imem_req;
    logic [PC_W-1:0] imem_addr;
    logic            imem_ack = 1'b0;
    logic [7:0]      imem_rdata = 8'h00;
    logic            dmem_req;
    logic            dmem_we;
    logic            dmem_ack = 1'b0;
    logic            alu_zero = 1'b0;
    logic [2:0]      alu_control;
    logic            alu_src;
    logic            alu_cmp;
    logic            wren_reg;
    logic            datamem_toreg;
    logic            link_sel;
    logic [PC_W-1:0] pc;
    logic [7:0]      ir;
    logic [2:0]      state;
`ifdef SINGLE_STEP_EN
    logic            step = 1'b1;
`endif

    always #5 clk = ~clk;

    multicycle_sequencer #(.PC_W(PC_W), .RESET_PC(0)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .dmem_req     (dmem_req),
        .dmem_we      (dmem_we),
        .dmem_ack     (dmem_ack),
        .alu_zero     (alu_zero),
        .alu_control  (alu_control),
        .alu_src      (alu_src),
        .alu_cmp      (alu_cmp),
        .wren_reg     (wren_reg),
        .datamem_toreg(datamem_toreg),
        .link_sel     (link_sel),
        .pc           (pc),
        .ir           (ir),
        .state        (state)
`ifdef SINGLE_STEP_EN
        ,
        .step         (step)
`endif
    );

    typedef struct {
        logic [7:0] instr;
        int         lat;
        logic [7:0] next_pc;
        int         n_wren;
        logic       toreg;
        logic       link;
        int         n_dmem;
        logic       we;
        logic       chk_alu;
        logic       chk_ctrl;
        logic [2:0] ctrl;
        logic       src;
        logic       cmp;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] forced_ins[$];
    logic       forced_z[$];
    int         forced_dw[$];

    int         n_tests   = 0;
    int         n_fail    = 0;
    int         n_issued  = 0;
    int         n_checked = 0;
    int         n_limit   = 0;
    int         cur_dwait = 0;
    logic [7:0] model_pc  = 8'h00;
    logic       mon_en    = 1'b0;
    logic       dmem_hold = 1'b0;
    logic       force_dack = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Reference model: what one instruction fetched at fpc must do, given the
    // ALU zero flag and data-memory wait states chosen for it.
    function automatic exp_t model(input logic [7:0] fpc, input logic [7:0] ins,
                                   input logic z, input int dw);
        exp_t       e;
        int         op;
        int         off;
        int         pc1;
        int         tgt;
        logic [7:0] tgt8;
        logic [7:0] pc18;
        op   = int'(ins[7:4]);
        off  = ins[3] ? int'(ins[3:0]) - 16 : int'(ins[3:0]);
        pc1  = (int'(fpc) + 1) % 256;
        tgt  = ((pc1 + off) % 256 + 256) % 256;
        tgt8 = tgt[7:0];
        pc18 = pc1[7:0];
        e.instr = ins; e.lat = 4; e.next_pc = pc18; e.n_wren = 1;
        e.toreg = 1'b0; e.link = 1'b0; e.n_dmem = 0; e.we = 1'b0;
        e.chk_alu = 1'b1; e.chk_ctrl = 1'b1; e.ctrl = ins[6:4]; e.src = 1'b0; e.cmp = 1'b0;
        case (op)
            8:  begin e.lat = 3; e.n_wren = 0; e.next_pc = tgt8; e.chk_alu = 1'b0; e.chk_ctrl = 1'b0; end
            9:  begin e.next_pc = tgt8; e.link = 1'b1; e.chk_alu = 1'b0; e.chk_ctrl = 1'b0; end
            10: begin e.ctrl = 3'b001; e.src = 1'b1; e.lat = 5 + dw; e.n_dmem = 1; e.toreg = 1'b1; end
            11: begin e.ctrl = 3'b001; e.src = 1'b1; e.lat = 4 + dw; e.n_dmem = 1; e.we = 1'b1; e.n_wren = 0; end
            12, 13: begin
                e.lat = 3; e.n_wren = 0; e.cmp = 1'b1; e.chk_ctrl = 1'b0;
                e.next_pc = (z == (op == 12)) ? tgt8 : pc18;
            end
            14: begin e.ctrl = 3'b001; e.src = 1'b1; end
            15: begin e.ctrl = 3'b000; e.src = 1'b1; end
            default: ;
        endcase
        e.lat = e.lat + c_STEP_EXTRA;
        return e;
    endfunction

    // Instruction memory: random wait states, directed program first, then
    // random instructions; every delivered instruction feeds the scoreboard.
    initial begin : imem_resp
        int         wleft;
        logic [7:0] ins;
        logic       z;
        int         dw;
        exp_t       e;
        wleft = -1;
        forever begin
            @(posedge clk);
            #1;
            imem_ack = 1'b0;
            if (!rst_n) begin
                wleft = -1;
                continue;
            end
            if (imem_req && n_issued < n_limit) begin
                if (wleft < 0) wleft = $urandom_range(0, 2);
                if (wleft == 0) begin
                    if (forced_ins.size() > 0) begin
                        ins = forced_ins.pop_front();
                        z   = forced_z.pop_front();
                        dw  = forced_dw.pop_front();
                    end else begin
                        ins = 8'($urandom);
                        z   = 1'($urandom);
                        dw  = $urandom_range(0, 3);
                    end
                    imem_ack   = 1'b1;
                    imem_rdata = ins;
                    alu_zero   = z;
                    cur_dwait  = dw;
                    if (mon_en) begin
                        e = model(model_pc, ins, z, dw);
                        sb.push_back(e);
                        model_pc = e.next_pc;
                    end
                    n_issued++;
                    wleft = -1;
                end else begin
                    wleft--;
                end
            end
        end
    end

    // Data memory: acknowledges after the wait count chosen at fetch time.
    initial begin : dmem_resp
        int dleft;
        dleft = -1;
        forever begin
            @(posedge clk);
            #1;
            dmem_ack = force_dack;
            if (!rst_n) begin
                dleft = -1;
                continue;
            end
            if (dmem_req && !dmem_hold) begin
                if (dleft < 0) dleft = cur_dwait;
                if (dleft == 0) begin
                    dmem_ack = 1'b1;
                    dleft    = -1;
                end else begin
                    dleft--;
                end
            end
        end
    end

    // Monitor: observes each instruction from its fetch acknowledge to the
    // next fetch request, then compares against the scoreboard entry.
    initial begin : monitor
        int         cyc;
        int         t_ack;
        logic       open;
        int         nwren;
        int         ndmem;
        logic       got_toreg;
        logic       got_link;
        logic       got_we;
        logic [2:0] got_ctrl;
        logic       got_src;
        logic       got_cmp;
        logic       dec_bad;
        exp_t       e;
        cyc = 0; t_ack = 0; open = 1'b0;
        nwren = 0; ndmem = 0; got_toreg = 1'b0; got_link = 1'b0; got_we = 1'b0;
        got_ctrl = 3'b000; got_src = 1'b0; got_cmp = 1'b0; dec_bad = 1'b0;
        forever begin
            @(negedge clk);
            if (!mon_en) begin
                open = 1'b0;
                continue;
            end
            cyc++;
            if (open) begin
                if (state == 3'd1 && (alu_control != 3'b000 || alu_src || alu_cmp ||
                                      wren_reg || dmem_req || imem_req))
                    dec_bad = 1'b1;
                if (state == 3'd2) begin
                    got_ctrl = alu_control; got_src = alu_src; got_cmp = alu_cmp;
                end
                if (wren_reg) begin
                    nwren++; got_toreg = datamem_toreg; got_link = link_sel;
                end
                if (dmem_req && dmem_ack) begin
                    ndmem++; got_we = dmem_we;
                end
                if (imem_req && cyc > t_ack) begin
                    open = 1'b0;
                    n_checked++;
                    if (sb.size() == 0) begin
                        n_tests++; n_fail++;
                        $display("FAIL scoreboard_empty: instruction retired with no expectation");
                    end else begin
                        e = sb.pop_front();
                        check($sformatf("latency[%0h]", e.instr), 32'(cyc - t_ack), 32'(e.lat));
                        check($sformatf("next_pc[%0h]", e.instr), 32'(imem_addr), 32'(e.next_pc));
                        check($sformatf("wren_pulses[%0h]", e.instr), 32'(nwren), 32'(e.n_wren));
                        check($sformatf("decode_quiet[%0h]", e.instr), 32'(dec_bad), 32'd0);
                        check($sformatf("dmem_accesses[%0h]", e.instr), 32'(ndmem), 32'(e.n_dmem));
                        if (e.n_wren > 0) begin
                            check($sformatf("datamem_toreg[%0h]", e.instr), 32'(got_toreg), 32'(e.toreg));
                            check($sformatf("link_sel[%0h]", e.instr), 32'(got_link), 32'(e.link));
                        end
                        if (e.n_dmem > 0)
                            check($sformatf("dmem_we[%0h]", e.instr), 32'(got_we), 32'(e.we));
                        if (e.chk_alu) begin
                            check($sformatf("alu_src[%0h]", e.instr), 32'(got_src), 32'(e.src));
                            check($sformatf("alu_cmp[%0h]", e.instr), 32'(got_cmp), 32'(e.cmp));
                        end
                        if (e.chk_ctrl)
                            check($sformatf("alu_control[%0h]", e.instr), 32'(got_ctrl), 32'(e.ctrl));
                    end
                end
            end
            if (imem_req && imem_ack) begin
                open = 1'b1; t_ack = cyc;
                nwren = 0; ndmem = 0; dec_bad = 1'b0;
                got_toreg = 1'b0; got_link = 1'b0; got_we = 1'b0;
                got_ctrl = 3'b000; got_src = 1'b0; got_cmp = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int i;
        // Directed program: add, j to 5, beq taken/not taken, bne, lw with
        // three waits, sw, jal backwards; then random traffic.
        forced_ins = '{8'h13, 8'h83, 8'hC3, 8'hA2, 8'hB0, 8'hC3, 8'hD3, 8'h9E, 8'h8F, 8'hD2};
        forced_z   = '{1'b0,  1'b0,  1'b1,  1'b0,  1'b0,  1'b0,  1'b0,  1'b0,  1'b0,  1'b1};
        forced_dw  = '{0,     0,     0,     3,     0,     0,     0,     0,     0,     0};

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("rst_state", 32'(state), 32'd0);
        check("rst_pc", 32'(pc), 32'd0);
        check("rst_ir", 32'(ir), 32'd0);
        check("rst_imem_req", 32'(imem_req), 32'd0);
        check("rst_strobes", 32'({dmem_req, dmem_we, wren_reg, datamem_toreg, link_sel,
                                  alu_src, alu_cmp, alu_control}), 32'd0);

        mon_en  = 1'b1;
        n_limit = forced_ins.size() + N_RAND;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("imem_req_after_reset", 32'(imem_req), 32'(c_REQ_AFTER_RST));

        i = 0;
        while (i < 30000 && n_checked < n_limit) begin
            @(negedge clk);
            i++;
        end
        check("instructions_retired", 32'(n_checked), 32'(n_limit));
        check("scoreboard_drained", 32'(sb.size()), 32'd0);

        // Reset in the middle of a data access.
        mon_en    = 1'b0;
        dmem_hold = 1'b1;
        n_limit   = 32'h3FFF_FFFF;
        i = 0;
        while (i < 3000 && !(dmem_req && state == 3'd3)) begin
            @(negedge clk);
            i++;
        end
        check("reached_mem_state", 32'(dmem_req && state == 3'd3), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("midmem_rst_state", 32'(state), 32'd0);
        check("midmem_rst_pc", 32'(pc), 32'd0);
        check("midmem_rst_reqs", 32'({imem_req, dmem_req, dmem_we}), 32'd0);
        check("midmem_rst_strobes", 32'({wren_reg, datamem_toreg, link_sel, alu_src,
                                         alu_cmp, alu_control}), 32'd0);
        sb.delete();
        dmem_hold  = 1'b0;
        force_dack = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("late_ack_state", 32'(state), 32'd0);
        check("late_ack_dmem_req", 32'(dmem_req), 32'd0);
        check("late_ack_imem_req", 32'(imem_req), 32'(c_REQ_AFTER_RST));
        check("late_ack_pc", 32'(pc), 32'd0);
        force_dack = 1'b0;
        repeat (2) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
